// File: rtl/Common.sv
// Shared register-file definitions used across the pipeline.
package Common;
    localparam int NUM_REGS = 32;
    typedef logic [4:0] RegIdx;
endpackage

// File: rtl/reg_scoreboard_pkg.sv
// Scoreboard-local constants and types.
package reg_scoreboard_pkg;
    localparam int STALL_W = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;
    typedef logic [Common::NUM_REGS-1:0] reg_mask_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/flush bundle between decode (master) and the scoreboard (slave).
interface reg_scoreboard_if;
    import Common::*;
    import reg_scoreboard_pkg::*;

    logic                issue_valid;
    RegIdx               issue_rs1;
    RegIdx               issue_rs2;
    logic                issue_rs1_used;
    logic                issue_rs2_used;
    RegIdx               issue_rd;
    logic                issue_rd_wen;
    logic                wb_valid;
    RegIdx               wb_rd;
    logic                flush;
    logic                issue_ready;
    logic                stall;
    reg_mask_t           busy_mask;
    logic [STALL_W-1:0]  stall_cycles;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_wen, wb_valid, wb_rd, flush,
        input  issue_ready, stall, busy_mask, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_wen, wb_valid, wb_rd, flush,
        output issue_ready, stall, busy_mask, stall_cycles
    );
endinterface

// File: rtl/reg_scoreboard_cnt.sv
// One register's in-flight write counter: saturating up/down with synchronous clear.
module reg_scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic busy_o,
    output logic full_o,
    output logic one_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_eff;

    // A writeback to an idle register has nothing to retire.
    assign dec_eff = dec_i && busy_o;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_eff && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec_eff && !inc_i) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign full_o = (cnt_q == CNT_MAX);
    assign one_o  = (cnt_q == CNT_ONE);
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per GPR and gates issue on RAW/overflow hazards.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle final writeback clear a source hazard.
module reg_scoreboard
    import Common::*;
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_scoreboard_if.slave  sb
);
    logic [NUM_REGS-1:0]  busy_vec;
    logic [NUM_REGS-1:0]  full_vec;
    logic [NUM_REGS-1:0]  one_vec;
    logic                 rs1_byp;
    logic                 rs2_byp;
    logic                 rs1_haz;
    logic                 rs2_haz;
    logic                 ovf_haz;
    logic                 issue_ready;
    logic                 issue_fire;
    logic                 stall;
    logic [STALL_W-1:0]   stall_cycles_q;
    logic [STALL_W-1:0]   stall_cycles_d;

    // x0 carries no state and is never busy.
    assign busy_vec[0] = 1'b0;
    assign full_vec[0] = 1'b0;
    assign one_vec[0]  = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic inc;
            logic dec;
            assign inc = issue_fire && sb.issue_rd_wen && (sb.issue_rd == RegIdx'(gi));
            assign dec = sb.wb_valid && (sb.wb_rd == RegIdx'(gi));

            reg_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr_i  (sb.flush),
                .inc_i  (inc),
                .dec_i  (dec),
                .busy_o (busy_vec[gi]),
                .full_o (full_vec[gi]),
                .one_o  (one_vec[gi])
            );
        end
    endgenerate

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign rs1_byp = sb.wb_valid && (sb.wb_rd == sb.issue_rs1) && one_vec[sb.issue_rs1];
    assign rs2_byp = sb.wb_valid && (sb.wb_rd == sb.issue_rs2) && one_vec[sb.issue_rs2];
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    assign rs1_haz = sb.issue_rs1_used && (sb.issue_rs1 != '0) && busy_vec[sb.issue_rs1] && !rs1_byp;
    assign rs2_haz = sb.issue_rs2_used && (sb.issue_rs2 != '0) && busy_vec[sb.issue_rs2] && !rs2_byp;
    assign ovf_haz = sb.issue_rd_wen && (sb.issue_rd != '0) && full_vec[sb.issue_rd];

    assign issue_ready = !sb.flush && !rs1_haz && !rs2_haz && !ovf_haz;
    assign issue_fire  = sb.issue_valid && issue_ready;
    assign stall       = sb.issue_valid && !issue_ready;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && stall_cycles_q != STALL_MAX) begin
            stall_cycles_d = stall_cycles_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb.issue_ready  = issue_ready;
    assign sb.stall        = stall;
    assign sb.busy_mask    = busy_vec;
    assign sb.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: reference model feeds an expectation queue.
module tb_reg_scoreboard;
    localparam int MAXC = 3;

    typedef struct {
        logic [31:0] busy;
        logic [15:0] sc;
    } exp_t;

    logic clk;
    logic rst_n;
    reg_scoreboard_if sb_if ();

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cnt [32];
    int   m_sc = 0;
    exp_t exp_q [$];
    logic obs_ready;
    logic obs_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int r = 1; r < 32; r++) m[r] = (m_cnt[r] != 0);
        return m;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_sc = 0;
        exp_q.delete();
    endtask

    task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wen, input bit wbv, input int wbrd, input bit fl);
        exp_t e;
        bit   b1, b2, h1, h2, ov, rdy_e, stl_e, inc, dec;
        sb_if.issue_valid    = v;
        sb_if.issue_rs1      = 5'(rs1);
        sb_if.issue_rs1_used = u1;
        sb_if.issue_rs2      = 5'(rs2);
        sb_if.issue_rs2_used = u2;
        sb_if.issue_rd       = 5'(rd);
        sb_if.issue_rd_wen   = wen;
        sb_if.wb_valid       = wbv;
        sb_if.wb_rd          = 5'(wbrd);
        sb_if.flush          = fl;
        #1;
        b1 = 1'b0;
        b2 = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        b1 = wbv && (wbrd == rs1) && (m_cnt[rs1] == 1);
        b2 = wbv && (wbrd == rs2) && (m_cnt[rs2] == 1);
`endif
        h1    = u1 && (rs1 != 0) && (m_cnt[rs1] != 0) && !b1;
        h2    = u2 && (rs2 != 0) && (m_cnt[rs2] != 0) && !b2;
        ov    = wen && (rd != 0) && (m_cnt[rd] == MAXC);
        rdy_e = !fl && !h1 && !h2 && !ov;
        stl_e = v && !rdy_e;
        obs_ready = sb_if.issue_ready;
        obs_stall = sb_if.stall;
        check("issue_ready", 32'(obs_ready), 32'(rdy_e));
        check("stall", 32'(obs_stall), 32'(stl_e));
        if (fl) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            inc = v && rdy_e && wen && (rd != 0);
            dec = wbv && (wbrd != 0) && (m_cnt[wbrd] != 0);
            if (inc) m_cnt[rd]++;
            if (dec) m_cnt[wbrd]--;
        end
        if (stl_e && m_sc != 'hFFFF) m_sc++;
        e.busy = model_mask();
        e.sc   = 16'(m_sc);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("busy_mask", sb_if.busy_mask, e.busy);
        check("stall_cycles", 32'(sb_if.stall_cycles), 32'(e.sc));
        $display("t=%0t iss v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b wb=%0b/%0d fl=%0b -> rdy=%0b busy=%h sc=%0d",
                 $time, v, rs1, u1, rs2, u2, rd, wen, wbv, wbrd, fl, obs_ready,
                 sb_if.busy_mask, sb_if.stall_cycles);
    endtask

    task automatic idle_inputs();
        sb_if.issue_valid    = 1'b0;
        sb_if.issue_rs1      = '0;
        sb_if.issue_rs2      = '0;
        sb_if.issue_rs1_used = 1'b0;
        sb_if.issue_rs2_used = 1'b0;
        sb_if.issue_rd       = '0;
        sb_if.issue_rd_wen   = 1'b0;
        sb_if.wb_valid       = 1'b0;
        sb_if.wb_rd          = '0;
        sb_if.flush          = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check("rst_busy", sb_if.busy_mask, 32'h0);
        check("rst_sc", 32'(sb_if.stall_cycles), 32'h0);
        check("rst_ready", 32'(sb_if.issue_ready), 32'h1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAW hazard on x5
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        check("s034_busy", sb_if.busy_mask, 32'h20);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("s034_stall", 32'(obs_stall), 32'h1);
        step(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("s034_byp_ready", 32'(obs_ready), 32'h1);
`else
        check("s034_wb_ready", 32'(obs_ready), 32'h0);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("s034_next_ready", 32'(obs_ready), 32'h1);
`endif

        // x0 never tracked
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        check("s035_ready", 32'(obs_ready), 32'h1);
        check("s035_busy", sb_if.busy_mask, 32'h0);

        // counter overflow on x7
        repeat (3) step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        check("s036_busy", sb_if.busy_mask, 32'h80);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        check("s036_ovf", 32'(obs_ready), 32'h0);
        step(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        check("s036_after_wb", 32'(obs_ready), 32'h1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        check("s036_drained", sb_if.busy_mask, 32'h0);

        // simultaneous issue + writeback to x9
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
        check("s037_bit9", sb_if.busy_mask & 32'h200, 32'h200);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        check("s037_free", sb_if.busy_mask, 32'h0);

        // writebacks to idle register and x0
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // flush clears everything
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
        check("s038_busy", sb_if.busy_mask, 32'h660);
        step(1, 0, 0, 0, 0, 1, 1, 1, 5, 1);
        check("s038_ready", 32'(obs_ready), 32'h0);
        check("s038_cleared", sb_if.busy_mask, 32'h0);

        // random traffic on a narrow register window
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 31) == 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // long stall saturates, then asynchronous reset mid-stall
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        sb_if.issue_valid    = 1'b1;
        sb_if.issue_rs1      = 5'd5;
        sb_if.issue_rs1_used = 1'b1;
        sb_if.issue_rd_wen   = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("s039_sat", 32'(sb_if.stall_cycles), 32'hFFFF);
        check("s039_stall", 32'(sb_if.stall), 32'h1);
        rst_n = 1'b0;
        #1;
        check("s039_rst_busy", sb_if.busy_mask, 32'h0);
        check("s039_rst_sc", 32'(sb_if.stall_cycles), 32'h0);
        check("s039_rst_stall", 32'(sb_if.stall), 32'h0);
        idle_inputs();
        #3 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // stale writeback after reset has no effect
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        check("s028_busy", sb_if.busy_mask, 32'h0);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("s028_ready", 32'(obs_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2, width of each per-register in-flight write counter (max outstanding writes per register = 2^CNT_W-1).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 issue_valid  input  1  decode presents an instruction for issue.
REQ-005 issue_rs1 / issue_rs2  input  5 each  source register indices.
REQ-006 issue_rs1_used / issue_rs2_used  input  1 each  source actually read by the opcode.
REQ-007 issue_rd  input  5  destination index; issue_rd_wen input 1, instruction writes rd.
REQ-008 wb_valid  input  1  writeback port commits; wb_rd input 5, index written.
REQ-009 flush  input  1  squash all in-flight instructions.
REQ-010 issue_ready  output  1  issue accepted this cycle (issue handshake = issue_valid & issue_ready).
REQ-011 stall  output  1  issue_valid & !issue_ready.
REQ-012 busy_mask  output  32  bit i set when counter[i] != 0; bit 0 always 0.
REQ-013 stall_cycles  output  16  saturating count of cycles with stall high.

Function
REQ-014 Per-register counter cnt[i], CNT_W bits, i = 1..31; x0 has no state and is never busy.
REQ-015 Source hazard: rsN_used & rsN != 0 & cnt[rsN] != 0.
REQ-016 Overflow hazard: issue_rd_wen & issue_rd != 0 & cnt[issue_rd] == max value.
REQ-017 issue_ready is combinational = !flush & no source hazard & no overflow hazard.
REQ-018 On accepted issue with rd_wen and rd != 0: cnt[rd] increments next edge.
REQ-019 On wb_valid with wb_rd != 0 and cnt[wb_rd] != 0: cnt[wb_rd] decrements next edge.
REQ-020 wb_valid to a register with cnt == 0 or to x0: no state change.
REQ-021 Same-cycle accepted issue and writeback to same rd: cnt unchanged.
REQ-022 Issue with rd_wen and rd == 0 is accepted without counter change.
REQ-023 flush high: all cnt cleared next edge; same-cycle issue and writeback ignored; issue_ready low.
REQ-024 stall_cycles increments each edge stall is high, saturates at 0xFFFF, never wraps.
REQ-025 busy_mask reflects registered counters only (no combinational update from same-cycle inputs).
REQ-026 No latency beyond one edge: a register becomes busy the cycle after its issue and free the cycle after its final writeback.

Reset
REQ-027 rst_n low asynchronously clears all cnt, busy_mask = 0, stall_cycles = 0; issue_ready = !flush while in reset-released idle.
REQ-028 Reset mid-operation discards all in-flight tracking; no writeback after reset alters state until re-issued.

Configuration
REQ-029 Macro SCOREBOARD_WB_BYPASS_EN defined: a source hazard on register r is suppressed when wb_valid & wb_rd == r & cnt[r] == 1 in the same cycle.
REQ-030 Macro undefined: source hazard evaluated on registered cnt only; such an instruction stalls exactly one extra cycle.

Structure
REQ-031 RegIdx (5-bit) typedef and NUM_REGS = 32 constant belong in package Common.
REQ-032 One sub-module is natural: reg_scoreboard_cnt, a single up/down saturating counter instantiated 31 times.
REQ-033 stall_cycles counter implemented inline, not as a sub-module.

Verification
REQ-034 Issue rd=5, next cycle issue rs1=5 used -> stall=1, issue_ready=0, busy_mask=0x20; wb_rd=5 -> next cycle issue_ready=1 (with bypass: ready in the wb cycle).
REQ-035 Issue rd=0 then rs1=0 used -> never stalls, busy_mask stays 0.
REQ-036 CNT_W=2, three issues rd=7 back to back -> cnt[7]=3; fourth issue rd=7 -> stall via overflow until one wb_rd=7.
REQ-037 cnt[9]=1, same cycle accepted issue rd=9 and wb_rd=9 -> cnt[9] stays 1, busy_mask bit 9 set.
REQ-038 busy_mask=0x0000_0660, flush=1 one cycle -> next cycle busy_mask=0, issue_ready=0 during flush cycle.
REQ-039 Hold a source hazard 70000 cycles -> stall_cycles=0xFFFF; assert rst_n low mid-stall -> all outputs 0 immediately, without a clock edge.
